// File: rtl/start_signal_poller.sv
// Periodic Avalon-MM poller: reads one word, captures the low DATA_WIDTH bits,
// and flags value changes and rising edges of a monitored start bit.
module start_signal_poller #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned POLL_GAP     = 1000,
  parameter logic [1:0]  POLL_ADDR    = 2'd0,
  parameter int unsigned START_BIT    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic [1:0]            avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           avm_readdata,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  output logic                  changed,
  output logic                  start_pulse,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, LAT, GAP} state_t;

  localparam logic [2:0]  LAT_LOAD = 3'(READ_LATENCY);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  state_t                state, state_next;
  logic [2:0]            lat_cnt, lat_next;
  logic [15:0]           gap_cnt, gap_next;
  logic                  capture;
  logic                  have_prior;
  logic [DATA_WIDTH-1:0] new_data;

  assign new_data = avm_readdata[DATA_WIDTH-1:0];

  if (DATA_WIDTH < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^avm_readdata[31:DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_next;
      gap_cnt <= gap_next;
    end
  end

  always_comb begin
    state_next = state;
    lat_next   = lat_cnt;
    gap_next   = gap_cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = ISSUE;
      end
      // an issued read is never withdrawn; enable is only consulted after capture
      ISSUE: begin
        if (!avm_waitrequest) begin
          state_next = LAT;
          lat_next   = LAT_LOAD;
        end
      end
      LAT: begin
        if (lat_cnt <= 3'd1) begin
          capture    = 1'b1;
          lat_next   = '0;
          gap_next   = '0;
          state_next = enable ? GAP : IDLE;
        end else begin
          lat_next = lat_cnt - 3'd1;
        end
      end
      GAP: begin
        if (!enable) begin
          state_next = IDLE;
          gap_next   = '0;
        end else if (gap_cnt == GAP_LAST) begin
          state_next = ISSUE;
          gap_next   = '0;
        end else begin
          gap_next = gap_cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // history survives enable toggles; only reset clears the prior-sample flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample       <= '0;
      have_prior   <= 1'b0;
      sample_valid <= 1'b0;
      changed      <= 1'b0;
      start_pulse  <= 1'b0;
    end else begin
      sample_valid <= capture;
      changed      <= capture && have_prior && (new_data != sample);
      start_pulse  <= capture && have_prior && !sample[START_BIT] && new_data[START_BIT];
      if (capture) begin
        sample     <= new_data;
        have_prior <= 1'b1;
      end
    end
  end

  assign avm_read    = (state == ISSUE);
  assign avm_address = POLL_ADDR;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_start_signal_poller.sv
// Directed bench for start_signal_poller: a default-parameter instance driven by
// a vector table and corner sequences, plus a latency-3 instance.
module tb_start_signal_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        en_a, wr_a, read_a, sv_a, ch_a, sp_a, busy_a;
  logic [31:0] rd_a;
  logic [1:0]  addr_a;
  logic [11:0] smp_a;
  logic        en_b, wr_b, read_b, sv_b, ch_b, sp_b, busy_b;
  logic [31:0] rd_b;
  logic [1:0]  addr_b;
  logic [11:0] smp_b;

  start_signal_poller dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a),
    .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wr_a),
    .avm_readdata(rd_a), .sample(smp_a), .sample_valid(sv_a),
    .changed(ch_a), .start_pulse(sp_a), .busy(busy_a)
  );

  start_signal_poller #(.READ_LATENCY(3), .POLL_GAP(4), .POLL_ADDR(2'd2)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b),
    .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wr_b),
    .avm_readdata(rd_b), .sample(smp_b), .sample_valid(sv_b),
    .changed(ch_b), .start_pulse(sp_b), .busy(busy_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_read_a(input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (read_a) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_a_timeout: no avm_read within %0d cycles", bound);
    end
  endtask

  task automatic wait_valid_a(input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (sv_a) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_a_timeout: no sample_valid within %0d cycles", bound);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [11:0] smp;
    logic        chg;
    logic        stp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t, last, tv, cnt;

    vecs[0] = '{32'h0000_0ABC, 12'hABC, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0ABC, 12'hABC, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0000, 12'h000, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0001, 12'h001, 1'b1, 1'b1};
    vecs[4] = '{32'hFFFF_F001, 12'h001, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0002, 12'h002, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0003, 12'h003, 1'b1, 1'b1};

    reset_n = 1'b0;
    en_a = 1'b0; wr_a = 1'b0; rd_a = '0;
    en_b = 1'b0; wr_b = 1'b0; rd_b = '0;
    t = 0; last = 0; tv = 0; cnt = 0;

    repeat (3) @(negedge clk);
    chk("rst_read_a", {31'd0, read_a}, 32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_sv_a", {31'd0, sv_a}, 32'd0);
    chk("rst_smp_a", {20'd0, smp_a}, 32'd0);
    chk("rst_addr_a", {30'd0, addr_a}, 32'd0);
    chk("rst_addr_b", {30'd0, addr_b}, 32'd2);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);

    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy_a", {31'd0, busy_a}, 32'd0);

    // first read one cycle after enable is sampled
    en_a = 1'b1;
    rd_a = vecs[0].rdata;
    @(negedge clk);
    chk("first_read_a", {31'd0, read_a}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        wait_read_a(1100, t);
        chk($sformatf("period_%0d", i), 32'(t - last), 32'd1002);
      end else begin
        t = cyc;
      end
      last = t;
      chk($sformatf("addr_%0d", i), {30'd0, addr_a}, 32'd0);
      wait_valid_a(10, tv);
      chk($sformatf("latency_%0d", i), 32'(tv - t), 32'd2);
      chk($sformatf("sample_%0d", i), {20'd0, smp_a}, {20'd0, vecs[i].smp});
      chk($sformatf("changed_%0d", i), {31'd0, ch_a}, {31'd0, vecs[i].chg});
      chk($sformatf("start_%0d", i), {31'd0, sp_a}, {31'd0, vecs[i].stp});
      if (i < 6) rd_a = vecs[i + 1].rdata;
      @(negedge clk);
      chk($sformatf("valid_pulse_%0d", i), {31'd0, sv_a}, 32'd0);
      chk($sformatf("gap_busy_%0d", i), {31'd0, busy_a}, 32'd1);
    end

    // stalled read with enable dropped mid-stall
    wr_a = 1'b1;
    rd_a = 32'h0000_00AA;
    wait_read_a(1100, t);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_read_%0d", k), {31'd0, read_a}, 32'd1);
      if (k == 2) en_a = 1'b0;
      if (k == 5) wr_a = 1'b0;
    end
    @(negedge clk);
    chk("stall_lat_read", {31'd0, read_a}, 32'd0);
    chk("stall_lat_busy", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    chk("stall_valid", {31'd0, sv_a}, 32'd1);
    chk("stall_sample", {20'd0, smp_a}, 32'h0AA);
    chk("stall_changed", {31'd0, ch_a}, 32'd1);
    chk("stall_start", {31'd0, sp_a}, 32'd0);
    chk("stall_idle", {31'd0, busy_a}, 32'd0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (read_a || busy_a) cnt++;
    end
    chk("stall_stays_idle", 32'(cnt), 32'd0);

    // enable dropped in GAP, restored, same value returned
    en_a = 1'b1;
    rd_a = 32'h0000_05A5;
    @(negedge clk);
    chk("reen_read", {31'd0, read_a}, 32'd1);
    wait_valid_a(10, tv);
    chk("gap1_sample", {20'd0, smp_a}, 32'h5A5);
    chk("gap1_changed", {31'd0, ch_a}, 32'd1);
    en_a = 1'b0;
    @(negedge clk);
    chk("gap_drop_idle", {31'd0, busy_a}, 32'd0);
    cnt = 0;
    repeat (9) begin
      @(negedge clk);
      if (read_a || busy_a) cnt++;
    end
    chk("gap_drop_quiet", 32'(cnt), 32'd0);
    en_a = 1'b1;
    @(negedge clk);
    chk("gap_restore_read", {31'd0, read_a}, 32'd1);
    wait_valid_a(10, tv);
    chk("gap2_sample", {20'd0, smp_a}, 32'h5A5);
    chk("gap2_changed", {31'd0, ch_a}, 32'd0);
    chk("gap2_start", {31'd0, sp_a}, 32'd0);

    // reset during LAT abandons the read
    rd_a = 32'h0000_0777;
    wait_read_a(1100, t);
    @(negedge clk);
    reset_n = 1'b0;
    en_a = 1'b0;
    #1;
    chk("lat_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("lat_rst_read", {31'd0, read_a}, 32'd0);
    chk("lat_rst_sample", {20'd0, smp_a}, 32'd0);
    chk("lat_rst_flags", {29'd0, sv_a, ch_a, sp_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (sv_a) cnt++;
    end
    chk("lat_rst_no_valid", 32'(cnt), 32'd0);
    chk("lat_rst_sample_kept0", {20'd0, smp_a}, 32'd0);

    // first capture after reset never flags changed
    rd_a = 32'h0000_0123;
    en_a = 1'b1;
    @(negedge clk);
    chk("post_rst_read", {31'd0, read_a}, 32'd1);
    wait_valid_a(10, tv);
    chk("post_rst_sample", {20'd0, smp_a}, 32'h123);
    chk("post_rst_changed", {31'd0, ch_a}, 32'd0);
    chk("post_rst_start", {31'd0, sp_a}, 32'd0);
    en_a = 1'b0;

    // latency-3 instance: data valid only in the third cycle after accept
    en_b = 1'b1;
    rd_b = 32'hFFFF_F777;
    t = -1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (read_b) begin
        t = cyc;
        break;
      end
    end
    chk("b_read_seen", {31'd0, (t >= 0)}, 32'd1);
    chk("b_addr", {30'd0, addr_b}, 32'd2);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk($sformatf("b_no_valid_%0d", k), {31'd0, sv_b}, 32'd0);
        chk($sformatf("b_busy_%0d", k), {31'd0, busy_b}, 32'd1);
      end
      if (k == 3) rd_b = 32'hFFFF_F123;
      if (k == 4) rd_b = 32'hFFFF_F777;
    end
    chk("b_valid", {31'd0, sv_b}, 32'd1);
    chk("b_sample", {20'd0, smp_b}, 32'h123);
    chk("b_changed", {31'd0, ch_b}, 32'd0);
    last = t;
    t = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (read_b) begin
        t = cyc;
        break;
      end
    end
    chk("b_period", 32'(t - last), 32'd8);
    en_b = 1'b0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
